// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand steering, forwarding mux and
// load-use hazard detection for the 32-bit MIPS core.
module id_ex_stage #(
   parameter int NB_REG       = 32,
   parameter int NB_ALU_CTRLI = 4,
   parameter int NB_ADDR      = 5
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_stall,
   input  logic                    i_flush,
   input  logic                    i_valid,
   input  logic [NB_REG-1:0]       i_rs_data,
   input  logic [NB_REG-1:0]       i_rt_data,
   input  logic [NB_REG-1:0]       i_imm,
   input  logic [4:0]              i_shamt,
   input  logic [NB_ADDR-1:0]      i_rs_addr,
   input  logic [NB_ADDR-1:0]      i_rt_addr,
   input  logic [NB_ADDR-1:0]      i_rd_addr,
   input  logic [NB_ALU_CTRLI-1:0] i_alu_ctrl,
   input  logic                    i_alu_src,
   input  logic                    i_shift_src,
   input  logic                    i_reg_dst,
   input  logic                    i_reg_write,
   input  logic                    i_mem_read,
   input  logic                    i_mem_write,
   input  logic                    i_mem_to_reg,
   input  logic                    i_exmem_reg_write,
   input  logic [NB_ADDR-1:0]      i_exmem_rd,
   input  logic [NB_REG-1:0]       i_exmem_result,
   input  logic                    i_memwb_reg_write,
   input  logic [NB_ADDR-1:0]      i_memwb_rd,
   input  logic [NB_REG-1:0]       i_memwb_data,
   output logic [NB_REG-1:0]       o_alu_a,
   output logic [NB_REG-1:0]       o_alu_b,
   output logic [NB_ALU_CTRLI-1:0] o_alu_ctrl,
   output logic [NB_REG-1:0]       o_store_data,
   output logic [NB_ADDR-1:0]      o_write_reg,
   output logic                    o_reg_write,
   output logic                    o_mem_read,
   output logic                    o_mem_write,
   output logic                    o_mem_to_reg,
   output logic                    o_valid,
   output logic                    o_load_use_hazard
);

   logic [NB_REG-1:0]       stg_rs_data;
   logic [NB_REG-1:0]       stg_rt_data;
   logic [NB_REG-1:0]       stg_imm;
   logic [4:0]              stg_shamt;
   logic [NB_ADDR-1:0]      stg_rs_addr;
   logic [NB_ADDR-1:0]      stg_rt_addr;
   logic [NB_ADDR-1:0]      stg_write_reg;
   logic [NB_ALU_CTRLI-1:0] stg_alu_ctrl;
   logic                    stg_alu_src;
   logic                    stg_shift_src;
   logic                    stg_reg_write;
   logic                    stg_mem_read;
   logic                    stg_mem_write;
   logic                    stg_mem_to_reg;
   logic                    stg_valid;

   logic [NB_REG-1:0]       fwd_rs;
   logic [NB_REG-1:0]       fwd_rt;

   // Flush clears every field so a bubble carries no stale addresses into forwarding.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset || i_flush) begin
         stg_rs_data    <= '0;
         stg_rt_data    <= '0;
         stg_imm        <= '0;
         stg_shamt      <= '0;
         stg_rs_addr    <= '0;
         stg_rt_addr    <= '0;
         stg_write_reg  <= '0;
         stg_alu_ctrl   <= '0;
         stg_alu_src    <= 1'b0;
         stg_shift_src  <= 1'b0;
         stg_reg_write  <= 1'b0;
         stg_mem_read   <= 1'b0;
         stg_mem_write  <= 1'b0;
         stg_mem_to_reg <= 1'b0;
         stg_valid      <= 1'b0;
      end else if (!i_stall) begin
         stg_rs_data    <= i_rs_data;
         stg_rt_data    <= i_rt_data;
         stg_imm        <= i_imm;
         stg_shamt      <= i_shamt;
         stg_rs_addr    <= i_rs_addr;
         stg_rt_addr    <= i_rt_addr;
         stg_write_reg  <= i_reg_dst ? i_rd_addr : i_rt_addr;
         stg_alu_ctrl   <= i_alu_ctrl;
         stg_alu_src    <= i_alu_src;
         stg_shift_src  <= i_shift_src;
         stg_reg_write  <= i_reg_write;
         stg_mem_read   <= i_mem_read;
         stg_mem_write  <= i_mem_write;
         stg_mem_to_reg <= i_mem_to_reg;
         stg_valid      <= i_valid;
      end
   end

   // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
   always_comb begin
      fwd_rs = stg_rs_data;
      if (stg_valid && (stg_rs_addr != '0)) begin
         if (i_exmem_reg_write && (i_exmem_rd == stg_rs_addr))
            fwd_rs = i_exmem_result;
         else if (i_memwb_reg_write && (i_memwb_rd == stg_rs_addr))
            fwd_rs = i_memwb_data;
      end
   end

   always_comb begin
      fwd_rt = stg_rt_data;
      if (stg_valid && (stg_rt_addr != '0)) begin
         if (i_exmem_reg_write && (i_exmem_rd == stg_rt_addr))
            fwd_rt = i_exmem_result;
         else if (i_memwb_reg_write && (i_memwb_rd == stg_rt_addr))
            fwd_rt = i_memwb_data;
      end
   end

   assign o_alu_a      = stg_shift_src ? {{(NB_REG-5){1'b0}}, stg_shamt} : fwd_rs;
   assign o_alu_b      = stg_alu_src ? stg_imm : fwd_rt;
   assign o_store_data = fwd_rt;
   assign o_alu_ctrl   = stg_alu_ctrl;
   assign o_write_reg  = stg_write_reg;

   assign o_valid      = stg_valid;
   assign o_reg_write  = stg_valid & stg_reg_write;
   assign o_mem_read   = stg_valid & stg_mem_read;
   assign o_mem_write  = stg_valid & stg_mem_write;
   assign o_mem_to_reg = stg_valid & stg_mem_to_reg;

   assign o_load_use_hazard = stg_valid & stg_mem_read & (stg_write_reg != '0)
                            & ((stg_write_reg == i_rs_addr) | (stg_write_reg == i_rt_addr))
                            & i_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand sequences for
// stall/flush/async reset, and randomized traffic against a record-level model.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  shamt, rs_addr, rt_addr, rd_addr;
      logic [3:0]  alu_ctrl;
      logic        alu_src, shift_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
   } id_t;

   typedef struct packed {
      logic        ex_rw;
      logic [4:0]  ex_rd;
      logic [31:0] ex_res;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
   } fw_t;

   typedef struct packed {
      logic [31:0] a, b, st;
      logic [3:0]  ctrl;
      logic [4:0]  wr;
      logic        valid, rw, mr, mw, m2r, hz;
   } out_t;

   typedef struct packed {
      id_t        id;
      logic       stall, flush;
      fw_t        fw;
      logic [4:0] nrs, nrt;
      logic       nvalid;
      out_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst, stall, flush;
   id_t  id_in;
   fw_t  fw_in;
   id_t  m;

   logic [31:0] alu_a, alu_b, store_data;
   logic [3:0]  alu_ctrl;
   logic [4:0]  write_reg;
   logic        reg_write, mem_read, mem_write, mem_to_reg, valid, hazard;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   id_ex_stage dut (
      .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
      .i_valid(id_in.valid), .i_rs_data(id_in.rs_data), .i_rt_data(id_in.rt_data),
      .i_imm(id_in.imm), .i_shamt(id_in.shamt), .i_rs_addr(id_in.rs_addr),
      .i_rt_addr(id_in.rt_addr), .i_rd_addr(id_in.rd_addr), .i_alu_ctrl(id_in.alu_ctrl),
      .i_alu_src(id_in.alu_src), .i_shift_src(id_in.shift_src), .i_reg_dst(id_in.reg_dst),
      .i_reg_write(id_in.reg_write), .i_mem_read(id_in.mem_read),
      .i_mem_write(id_in.mem_write), .i_mem_to_reg(id_in.mem_to_reg),
      .i_exmem_reg_write(fw_in.ex_rw), .i_exmem_rd(fw_in.ex_rd), .i_exmem_result(fw_in.ex_res),
      .i_memwb_reg_write(fw_in.wb_rw), .i_memwb_rd(fw_in.wb_rd), .i_memwb_data(fw_in.wb_data),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl), .o_store_data(store_data),
      .o_write_reg(write_reg), .o_reg_write(reg_write), .o_mem_read(mem_read),
      .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg), .o_valid(valid),
      .o_load_use_hazard(hazard)
   );

   // Reference model: the stage simply holds the last accepted ID record.
   always @(posedge clk or posedge rst) begin
      if (rst || flush) m <= '0;
      else if (!stall) m <= id_in;
   end

   function automatic logic [31:0] ref_fwd(id_t s, fw_t f, logic [4:0] a, logic [31:0] d);
      logic        w [2];
      logic [4:0]  r [2];
      logic [31:0] v [2];
      w[0] = f.ex_rw; r[0] = f.ex_rd; v[0] = f.ex_res;
      w[1] = f.wb_rw; r[1] = f.wb_rd; v[1] = f.wb_data;
      if (!s.valid || a == 5'd0) return d;
      for (int k = 0; k < 2; k++)
         if (w[k] && r[k] == a) return v[k];
      return d;
   endfunction

   function automatic out_t ref_out(id_t s, fw_t f, logic [4:0] nrs, logic [4:0] nrt, logic nv);
      out_t o;
      logic [31:0] frs, frt;
      logic [4:0]  wr;
      wr    = s.reg_dst ? s.rd_addr : s.rt_addr;
      frs   = ref_fwd(s, f, s.rs_addr, s.rs_data);
      frt   = ref_fwd(s, f, s.rt_addr, s.rt_data);
      o.a   = s.shift_src ? 32'(s.shamt) : frs;
      o.b   = s.alu_src ? s.imm : frt;
      o.st  = frt;
      o.ctrl = s.alu_ctrl;
      o.wr  = wr;
      o.valid = s.valid;
      o.rw  = s.valid && s.reg_write;
      o.mr  = s.valid && s.mem_read;
      o.mw  = s.valid && s.mem_write;
      o.m2r = s.valid && s.mem_to_reg;
      o.hz  = s.valid && s.mem_read && wr != 0 && (wr == nrs || wr == nrt) && nv;
      return o;
   endfunction

   function automatic out_t mko(logic [31:0] a, logic [31:0] b, logic [31:0] st, logic [3:0] c,
                                logic [4:0] w, logic v, logic rw, logic mr, logic mw,
                                logic m2r, logic hz);
      out_t o;
      o.a = a; o.b = b; o.st = st; o.ctrl = c; o.wr = w; o.valid = v;
      o.rw = rw; o.mr = mr; o.mw = mw; o.m2r = m2r; o.hz = hz;
      return o;
   endfunction

   function automatic out_t get_out();
      return mko(alu_a, alu_b, store_data, alu_ctrl, write_reg, valid,
                 reg_write, mem_read, mem_write, mem_to_reg, hazard);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cmp_out(string tag, out_t e);
      out_t g;
      g = get_out();
      chk({tag, " alu_a"}, g.a, e.a);
      chk({tag, " alu_b"}, g.b, e.b);
      chk({tag, " store_data"}, g.st, e.st);
      chk({tag, " alu_ctrl"}, 32'(g.ctrl), 32'(e.ctrl));
      chk({tag, " write_reg"}, 32'(g.wr), 32'(e.wr));
      chk({tag, " valid"}, 32'(g.valid), 32'(e.valid));
      chk({tag, " reg_write"}, 32'(g.rw), 32'(e.rw));
      chk({tag, " mem_read"}, 32'(g.mr), 32'(e.mr));
      chk({tag, " mem_write"}, 32'(g.mw), 32'(e.mw));
      chk({tag, " mem_to_reg"}, 32'(g.m2r), 32'(e.m2r));
      chk({tag, " hazard"}, 32'(g.hz), 32'(e.hz));
   endtask

   // Capture phase before the edge, then forward sources and next-ID addresses after it.
   task automatic run_step(id_t id, logic st, logic fl, fw_t f, logic [4:0] nrs,
                           logic [4:0] nrt, logic nv);
      id_in = id; stall = st; flush = fl;
      @(posedge clk); #1;
      stall = 1'b0; flush = 1'b0;
      fw_in = f;
      id_in.rs_addr = nrs; id_in.rt_addr = nrt; id_in.valid = nv;
      @(negedge clk);
   endtask

   task automatic add(id_t id, logic st, logic fl, fw_t f, logic [4:0] nrs, logic [4:0] nrt,
                      logic nv, out_t e);
      vec_t v;
      v.id = id; v.stall = st; v.flush = fl; v.fw = f;
      v.nrs = nrs; v.nrt = nrt; v.nvalid = nv; v.exp = e;
      vecs.push_back(v);
   endtask

   id_t  a1, a2, a4, a5, a6, lw, lw0, sw, inv;
   fw_t  f0, f2, f3, f4, f5, f14, f15;
   out_t z;

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      id_in = '0; fw_in = '0; z = '0;

      a1 = '0; a1.valid = 1; a1.rs_data = 5; a1.rt_data = 7; a1.alu_ctrl = 3;
      a1.rs_addr = 1; a1.rt_addr = 2; a1.rd_addr = 3; a1.reg_dst = 1; a1.reg_write = 1;
      a2 = '0; a2.valid = 1; a2.rs_addr = 8; a2.rs_data = 32'h100; a2.rt_addr = 2;
      a2.rt_data = 32'h200; a2.alu_ctrl = 2;
      a4 = '0; a4.valid = 1; a4.rs_data = 32'h55; a4.rt_data = 32'h66; a4.alu_ctrl = 1;
      a5 = '0; a5.valid = 1; a5.shift_src = 1; a5.shamt = 4; a5.rt_addr = 6;
      a5.rt_data = 32'h99; a5.rs_addr = 7; a5.rs_data = 32'hAA; a5.imm = 32'hFFFF_FFFC;
      a5.alu_ctrl = 5; a5.rd_addr = 3; a5.reg_dst = 1; a5.reg_write = 1;
      a6 = a5; a6.alu_src = 1;
      lw = '0; lw.valid = 1; lw.mem_read = 1; lw.mem_to_reg = 1; lw.reg_write = 1;
      lw.rt_addr = 9; lw.rt_data = 32'h77; lw.rd_addr = 3; lw.rs_addr = 4;
      lw.rs_data = 32'h1000; lw.imm = 8; lw.alu_src = 1; lw.alu_ctrl = 2;
      lw0 = lw; lw0.rt_addr = 0;
      sw = '0; sw.valid = 1; sw.mem_write = 1; sw.rs_addr = 4; sw.rs_data = 32'h2000;
      sw.rt_addr = 5; sw.rt_data = 32'hABCD; sw.imm = 32'h10; sw.alu_src = 1; sw.alu_ctrl = 2;
      inv = '0; inv.reg_write = 1; inv.mem_write = 1; inv.mem_read = 1; inv.rs_addr = 3;
      inv.rs_data = 32'h33; inv.alu_ctrl = 6; inv.rt_addr = 4; inv.rt_data = 32'h44;

      f0 = '0;
      f2 = '0; f2.ex_rw = 1; f2.ex_rd = 8; f2.ex_res = 32'h11; f2.wb_rw = 1; f2.wb_rd = 8;
      f2.wb_data = 32'h22;
      f3 = f2; f3.ex_rw = 0;
      f4 = f2; f4.ex_rd = 0; f4.wb_rd = 0;
      f5 = '0; f5.ex_rw = 1; f5.ex_rd = 6; f5.ex_res = 32'h0F;
      f14 = '0; f14.ex_rw = 1; f14.ex_rd = 5; f14.ex_res = 32'hDEAD;
      f15 = '0; f15.ex_rw = 1; f15.ex_rd = 3; f15.ex_res = 32'h99;

      add(a1,  0, 0, f0,  0,  0,  0, mko(5, 7, 7, 3, 3, 1, 1, 0, 0, 0, 0));
      add(a2,  0, 0, f2,  0,  0,  0, mko(32'h11, 32'h200, 32'h200, 2, 2, 1, 0, 0, 0, 0, 0));
      add(a1,  1, 0, f3,  0,  0,  0, mko(32'h22, 32'h200, 32'h200, 2, 2, 1, 0, 0, 0, 0, 0));
      add(a4,  0, 0, f4,  0,  0,  0, mko(32'h55, 32'h66, 32'h66, 1, 0, 1, 0, 0, 0, 0, 0));
      add(a5,  0, 0, f5,  0,  0,  0, mko(4, 32'h0F, 32'h0F, 5, 3, 1, 1, 0, 0, 0, 0));
      add(a6,  0, 0, f5,  0,  0,  0, mko(4, 32'hFFFF_FFFC, 32'h0F, 5, 3, 1, 1, 0, 0, 0, 0));
      add(lw,  0, 0, f0,  9,  1,  1, mko(32'h1000, 8, 32'h77, 2, 9, 1, 1, 1, 0, 1, 1));
      add(a1,  1, 0, f0, 10, 11,  1, mko(32'h1000, 8, 32'h77, 2, 9, 1, 1, 1, 0, 1, 0));
      add(a1,  1, 0, f0,  0,  9,  0, mko(32'h1000, 8, 32'h77, 2, 9, 1, 1, 1, 0, 1, 0));
      add(a1,  1, 0, f0,  0,  9,  1, mko(32'h1000, 8, 32'h77, 2, 9, 1, 1, 1, 0, 1, 1));
      add(lw0, 0, 0, f0,  0,  0,  1, mko(32'h1000, 8, 32'h77, 2, 0, 1, 1, 1, 0, 1, 0));
      add(sw,  0, 0, f0,  0,  0,  0, mko(32'h2000, 32'h10, 32'hABCD, 2, 5, 1, 0, 0, 1, 0, 0));
      add(lw,  1, 0, f0,  0,  0,  0, mko(32'h2000, 32'h10, 32'hABCD, 2, 5, 1, 0, 0, 1, 0, 0));
      add(a5,  1, 0, f0,  0,  0,  0, mko(32'h2000, 32'h10, 32'hABCD, 2, 5, 1, 0, 0, 1, 0, 0));
      add(a1,  1, 1, f14, 5,  5,  1, z);
      add(inv, 0, 0, f15, 4,  0,  1, mko(32'h33, 32'h44, 32'h44, 6, 4, 0, 0, 0, 0, 0, 0));

      // Reset state, with address-0 forward sources driving junk.
      fw_in.ex_rw = 1; fw_in.ex_res = 32'hFFFF; fw_in.wb_rw = 1; fw_in.wb_data = 32'hEEEE;
      id_in = a1;
      repeat (2) @(negedge clk);
      cmp_out("reset", z);
      rst = 1'b0;

      foreach (vecs[i])
         begin
            run_step(vecs[i].id, vecs[i].stall, vecs[i].flush, vecs[i].fw,
                     vecs[i].nrs, vecs[i].nrt, vecs[i].nvalid);
            cmp_out($sformatf("vec%0d", i), vecs[i].exp);
         end

      // Async reset between edges with a valid store in the stage.
      run_step(sw, 0, 0, f0, 0, 0, 0);
      chk("pre_reset mem_write", 32'(mem_write), 1);
      #2 rst = 1'b1;
      #1;
      chk("async mem_write", 32'(mem_write), 0);
      chk("async valid", 32'(valid), 0);
      chk("async alu_b", alu_b, 0);
      #1 rst = 1'b0;
      #0.5;
      chk("post_reset valid", 32'(valid), 0);
      run_step(a1, 0, 0, f0, 0, 0, 0);
      cmp_out("first_capture", mko(5, 7, 7, 3, 3, 1, 1, 0, 0, 0, 0));

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         id_t  rid;
         fw_t  rf;
         logic rst_pulse;
         rid.valid = ($urandom_range(0, 7) != 0);
         rid.rs_data = $urandom; rid.rt_data = $urandom; rid.imm = $urandom;
         rid.shamt = 5'($urandom); rid.rs_addr = 5'($urandom_range(0, 7));
         rid.rt_addr = 5'($urandom_range(0, 7)); rid.rd_addr = 5'($urandom_range(0, 7));
         rid.alu_ctrl = 4'($urandom);
         rid.alu_src = 1'($urandom); rid.shift_src = ($urandom_range(0, 3) == 0);
         rid.reg_dst = 1'($urandom); rid.reg_write = 1'($urandom);
         rid.mem_read = 1'($urandom); rid.mem_write = 1'($urandom);
         rid.mem_to_reg = 1'($urandom);
         rf.ex_rw = 1'($urandom); rf.ex_rd = 5'($urandom_range(0, 7)); rf.ex_res = $urandom;
         rf.wb_rw = 1'($urandom); rf.wb_rd = 5'($urandom_range(0, 7)); rf.wb_data = $urandom;
         rst_pulse = ($urandom_range(0, 63) == 0);
         run_step(rid, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), rf,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
         if (rst_pulse) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
         cmp_out($sformatf("rand%0d", n),
                 ref_out(m, fw_in, id_in.rs_addr, id_in.rt_addr, id_in.valid));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand steering for the 32-bit MIPS core. Captures decoded operands and control from ID each cycle, supports stall (hold) and flush (bubble), and drives the ALU operand, control and store-data inputs through a forwarding mux fed by the EX/MEM and MEM/WB stages. Also flags load-use hazards back to the hazard/stall logic.

## Interface
- NB_REG, 32, datapath width
- NB_ALU_CTRLI, 4, ALU control code width
- NB_ADDR, 5, register-file address width
- i_clock  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_stall  in  1  hold all stage registers
- i_flush  in  1  load a bubble
- i_valid  in  1  ID instruction valid
- i_rs_data, i_rt_data  in  NB_REG  register-file read data
- i_imm  in  NB_REG  sign/zero-extended immediate
- i_shamt  in  5  shift amount field
- i_rs_addr, i_rt_addr, i_rd_addr  in  NB_ADDR  register fields
- i_alu_ctrl  in  NB_ALU_CTRLI  ALU operation code
- i_alu_src  in  1  1: operand B = immediate
- i_shift_src  in  1  1: operand A = zero-extended shamt
- i_reg_dst  in  1  1: write reg = rd, 0: rt
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1  control bits carried to MEM/WB
- i_exmem_reg_write  in  1, i_exmem_rd  in  NB_ADDR, i_exmem_result  in  NB_REG  EX/MEM forward source
- i_memwb_reg_write  in  1, i_memwb_rd  in  NB_ADDR, i_memwb_data  in  NB_REG  MEM/WB forward source
- o_alu_a, o_alu_b  out  NB_REG  ALU operands
- o_alu_ctrl  out  NB_ALU_CTRLI  ALU operation code
- o_store_data  out  NB_REG  forwarded rt for stores
- o_write_reg  out  NB_ADDR  destination register
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_valid  out  1  registered control
- o_load_use_hazard  out  1  stall request to ID

## Operation
- Register update on rising i_clock, priority: i_reset > i_flush > i_stall > capture.
- Capture: all i_* ID fields stored; stored write reg = i_reg_dst ? i_rd_addr : i_rt_addr; valid = i_valid.
- Flush: valid, reg_write, mem_read, mem_write, mem_to_reg, alu_ctrl, all data/address fields -> 0.
- Stall: all registers hold; forwarding outputs remain live (re-evaluated from current forward inputs).
- Forwarding (combinational, per source rs/rt): if stored valid, stored addr != 0, i_exmem_reg_write and i_exmem_rd == addr -> i_exmem_result; else if i_memwb_reg_write and i_memwb_rd == addr -> i_memwb_data; else stored register data. EX/MEM has priority over MEM/WB. Register 0 never forwarded (value is stored data).
- o_alu_a = shift_src ? {27'b0, shamt} : fwd_rs.
- o_alu_b = alu_src ? imm : fwd_rt.
- o_store_data = fwd_rt regardless of alu_src.
- Control outputs gated by valid: when valid = 0 all of o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg = 0.
- o_load_use_hazard = valid & stored mem_read & stored write reg != 0 & (write reg == i_rs_addr | write reg == i_rt_addr) & i_valid. Combinational; ID asserts i_stall and i_flush (bubble into this stage) next edge.

## Timing
- Reset (async): every registered field 0; outputs o_valid, o_reg_write, o_mem_*, o_mem_to_reg, o_load_use_hazard = 0, o_alu_ctrl = 0, o_write_reg = 0, o_alu_a/o_alu_b/o_store_data = 0 (forward sources with addr 0 ignored).
- Latency: ID inputs visible at outputs 1 cycle after the capturing edge.
- Forwarding path and hazard flag are zero-latency (same cycle as forward inputs / ID addresses).
- Simultaneous flush + stall: flush wins. Reset deasserted mid-cycle: first capture on next rising edge.
- No handshake; stall/flush are level signals sampled per edge.

## Test plan
- Reset then capture: rs_data=5, rt_data=7, alu_ctrl=3, alu_src=0 -> next cycle o_alu_a=5, o_alu_b=7, o_alu_ctrl=3, o_valid=1.
- EX/MEM vs MEM/WB priority: stored rs=8; exmem_rd=8 result=0x11, memwb_rd=8 data=0x22 -> o_alu_a=0x11; drop exmem_reg_write -> 0x22; set exmem_rd=0 with rs=0 -> stored data used.
- Shift/immediate steering: shift_src=1, shamt=4, rt forwarded 0x0F, alu_src=0 -> o_alu_a=4, o_alu_b=0x0F; alu_src=1, imm=0xFFFFFFFC -> o_alu_b=0xFFFFFFFC, o_store_data=0x0F.
- Load-use: stored lw to $9 (mem_read=1, reg_dst=0, rt=9), ID rs_addr=9 -> o_load_use_hazard=1; ID addresses 10/11 -> 0; write reg 0 -> 0.
- Stall then flush: capture A, assert i_stall 2 cycles with new ID inputs -> outputs stay A; assert i_stall and i_flush together -> o_valid=0, all control 0.
- Async reset mid-operation: assert i_reset between edges with valid store in stage -> o_mem_write and o_valid drop to 0 immediately without clock.
